fifo_stream_reader: RTL and testbench

Read-side consumer for the 2048x32 synchronous FIFO. Drains the FIFO read port (rd_en / rd_data with one-cycle read latency, no output register) into a valid/ready stream through a 2-entry skid buffer. It sustains one word per clock, marks frame boundaries with m_last, and checks the data against the down-counting pattern the write side produces. It sits directly behind the FIFO read port and feeds downstream stream logic.

---
 rtl/fifo_stream_reader.sv | 122 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a one-cycle-latency FIFO read port into a valid/ready stream through a 2-entry skid
// buffer. It marks frame ends and checks the words against a down-counting pattern.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN  = 2048,
  parameter bit          CHECK_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  en_i,
  input  logic                  clr_err_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_rd_empty_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic [15:0]           frame_cnt_o,
  output logic [7:0]            err_cnt_o,
  output logic                  err_flag_o
);

  localparam int unsigned WcntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e                state_q, state_d;
  logic                  inflight_q;
  logic [1:0]            occ_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [WcntW-1:0]      wcnt_q;
  logic [15:0]           frame_cnt_q;
  logic [7:0]            err_cnt_q;
  logic                  err_flag_q;
  logic [DATA_WIDTH-1:0] expected_q;

  logic       pop, is_last, mismatch;
  logic [1:0] occ_next;

  assign pop       = m_valid_o & m_ready_i;
  assign is_last   = (wcnt_q == WcntW'(FRAME_LEN - 1));
  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = buf_q[rd_ptr_q];
  assign m_last_o  = m_valid_o & is_last;
  assign mismatch  = CHECK_EN & pop & (m_data_o != expected_q);

  // Occupancy after this edge; a read is only issued if its word is guaranteed a slot.
  assign occ_next     = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign fifo_rd_en_o = (state_q == StRun) & ~fifo_rd_empty_i & (occ_next < 2'd2);

  assign busy_o      = (state_q != StIdle);
  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign err_flag_o  = err_flag_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (en_i) state_d = StRun;
      StRun:  if (!en_i) state_d = StStop;
      StStop: begin
        if (en_i) begin
          state_d = StRun;
        end else if (!inflight_q && (occ_q == 2'd0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q     <= StIdle;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wcnt_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en_o;
      occ_q      <= occ_next;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= fifo_rd_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        wcnt_q   <= is_last ? '0 : wcnt_q + WcntW'(1);
        if (is_last) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // On a mismatch the checker resyncs to the received word to avoid cascading errors.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      expected_q <= '1;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      if (pop && CHECK_EN) begin
        expected_q <= mismatch ? m_data_o - DATA_WIDTH'(1) : expected_q - DATA_WIDTH'(1);
      end
      if (clr_err_i) begin
        err_cnt_q  <= '0;
        err_flag_q <= 1'b0;
      end else if (mismatch) begin
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        err_flag_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural FIFO in front, stream checker behind.
module tb_fifo_stream_reader;
  localparam int unsigned FL = 2048;

  logic        clk = 1'b0;
  logic        tb_rst = 1'b1;
  logic        en = 1'b0;
  logic        clr_err = 1'b0;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_empty;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic        err_flag;

  fifo_stream_reader dut (
    .clk            (clk),
    .tb_rst         (tb_rst),
    .en_i           (en),
    .clr_err_i      (clr_err),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_rd_empty_i(fifo_rd_empty),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .m_data_o       (m_data),
    .m_last_o       (m_last),
    .busy_o         (busy),
    .frame_cnt_o    (frame_cnt),
    .err_cnt_o      (err_cnt),
    .err_flag_o     (err_flag)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after an accepted read.
  logic [31:0] mem [0:16383];
  int   rd_idx = 0;
  int   wr_idx = 0;
  logic fifo_flush = 1'b0;
  assign fifo_rd_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_idx <= wr_idx;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_idx];
      rd_idx       <= rd_idx + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, rx_cnt, rd_cnt, data_bad, last_bad, last_cnt, stall_bad, rule_bad, valid_bad;
  int first_rd_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc;
  int pop_idx, occ_m, infl_m, wm;
  logic        hold_v, last_last;
  logic [31:0] hold_d, first_data, last_data;
  logic [7:0]  err_at [0:15];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; rx_cnt = 0; rd_cnt = 0; data_bad = 0; last_bad = 0; last_cnt = 0;
    stall_bad = 0; rule_bad = 0; valid_bad = 0;
    first_rd_cyc = -1; first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    hold_v = 1'b0; hold_d = '0; first_data = '0; last_data = '0; last_last = 1'b0;
    for (int i = 0; i < 16; i++) err_at[i] = 8'hEE;
  endtask

  task automatic do_reset();
    @(negedge clk);
    tb_rst = 1'b1; en = 1'b0; m_ready = 1'b0; clr_err = 1'b0; fifo_flush = 1'b1;
    @(negedge clk);
    tb_rst = 1'b0; fifo_flush = 1'b0;
    pop_idx = wr_idx; occ_m = 0; infl_m = 0; wm = 0;
    clear_stats();
  endtask

  task automatic push(input int n, input logic [31:0] start);
    for (int i = 0; i < n; i++) begin
      mem[wr_idx] = start - 32'(i);
      wr_idx++;
    end
  endtask

  // One cycle: drive inputs, then observe the stream against the bench's own occupancy model.
  task automatic tick(input logic rdy, input logic en_v);
    int p;
    @(negedge clk);
    m_ready = rdy;
    en = en_v;
    #1;
    p = (m_valid && m_ready) ? 1 : 0;
    if (rx_cnt < 16) err_at[rx_cnt] = err_cnt;
    if (fifo_rd_en && (occ_m + infl_m - p >= 2)) rule_bad++;
    if (m_valid != (occ_m != 0)) valid_bad++;
    if (hold_v && (!m_valid || m_data != hold_d)) stall_bad++;
    hold_v = m_valid && !m_ready;
    hold_d = m_data;
    if (fifo_rd_en) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (p == 1) begin
      if (m_data !== mem[pop_idx]) data_bad++;
      if (m_last !== (wm == FL - 1)) last_bad++;
      if (m_last) last_cnt++;
      if (rx_cnt == 0) begin
        first_pop_cyc = cyc;
        first_data    = m_data;
      end
      last_pop_cyc = cyc;
      last_data    = m_data;
      last_last    = m_last;
      pop_idx++;
      rx_cnt++;
      wm = (wm == FL - 1) ? 0 : wm + 1;
    end
    occ_m  = occ_m + infl_m - p;
    infl_m = fifo_rd_en ? 1 : 0;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, n;

    // Reset values
    do_reset();
    #1;
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", m_data, 32'h0);
    check_eq("rst_m_last", 32'(m_last), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_err_flag", 32'(err_flag), 32'd0);

    // Full frame, m_ready held high
    do_reset();
    push(FL, 32'hFFFF_FFFF);
    while (rx_cnt < FL && cyc < 3000) tick(1'b1, 1'b1);
    check_eq("t1_first_rd_cyc", 32'(first_rd_cyc), 32'd1);
    check_eq("t1_first_valid_cyc", 32'(first_valid_cyc), 32'd3);
    check_eq("t1_rx_cnt", 32'(rx_cnt), 32'(FL));
    check_eq("t1_pop_span", 32'(last_pop_cyc - first_pop_cyc), 32'(FL - 1));
    check_eq("t1_first_data", first_data, 32'hFFFF_FFFF);
    check_eq("t1_last_data", last_data, 32'hFFFF_F800);
    check_eq("t1_last_flag", 32'(last_last), 32'd1);
    check_eq("t1_last_cnt", 32'(last_cnt), 32'd1);
    check_eq("t1_data_bad", 32'(data_bad), 32'd0);
    check_eq("t1_last_bad", 32'(last_bad), 32'd0);
    check_eq("t1_rd_cnt", 32'(rd_cnt), 32'(FL));
    tick(1'b1, 1'b1);
    check_eq("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check_eq("t1_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("t1_busy_run", 32'(busy), 32'd1);

    // Full frame, m_ready toggling every cycle
    do_reset();
    push(FL, 32'hFFFF_FFFF);
    while (rx_cnt < FL && cyc < 8000) tick(cyc % 2 == 0, 1'b1);
    for (int i = 0; i < 4; i++) tick(cyc % 2 == 0, 1'b1);
    check_eq("t2_rx_cnt", 32'(rx_cnt), 32'(FL));
    check_eq("t2_rd_cnt", 32'(rd_cnt), 32'(FL));
    check_eq("t2_data_bad", 32'(data_bad), 32'd0);
    check_eq("t2_stall_bad", 32'(stall_bad), 32'd0);
    check_eq("t2_rule_bad", 32'(rule_bad), 32'd0);
    check_eq("t2_valid_bad", 32'(valid_bad), 32'd0);
    check_eq("t2_frame_cnt", 32'(frame_cnt), 32'd1);
    check_eq("t2_err_cnt", 32'(err_cnt), 32'd0);

    // Corrupt word 10: the checker resyncs to it, so the next good word also counts once
    do_reset();
    base = wr_idx;
    push(FL, 32'hFFFF_FFFF);
    mem[base + 10] = 32'h1234_5678;
    while (rx_cnt < FL && cyc < 3000) tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check_eq("t3_err_before", 32'(err_at[10]), 32'd0);
    check_eq("t3_err_after_bad", 32'(err_at[11]), 32'd1);
    check_eq("t3_err_after_resync", 32'(err_at[12]), 32'd2);
    check_eq("t3_err_cnt", 32'(err_cnt), 32'd2);
    check_eq("t3_err_flag", 32'(err_flag), 32'd1);
    check_eq("t3_data_bad", 32'(data_bad), 32'd0);
    clr_err = 1'b1;
    tick(1'b1, 1'b1);
    clr_err = 1'b0;
    check_eq("t3_clr_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("t3_clr_err_flag", 32'(err_flag), 32'd0);
    // Mismatching word popped while clr_err is held: clear wins
    clr_err = 1'b1;
    push(1, 32'h0);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
    clr_err = 1'b0;
    check_eq("t3_clr_wins_rx", 32'(rx_cnt), 32'(FL + 1));
    check_eq("t3_clr_wins_cnt", 32'(err_cnt), 32'd0);
    check_eq("t3_clr_wins_flag", 32'(err_flag), 32'd0);

    // FIFO runs dry after 3 words
    do_reset();
    push(3, 32'hFFFF_FFFF);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1);
    check_eq("t4_rx_cnt", 32'(rx_cnt), 32'd3);
    check_eq("t4_rd_cnt", 32'(rd_cnt), 32'd3);
    check_eq("t4_m_valid", 32'(m_valid), 32'd0);
    check_eq("t4_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd1);
    check_eq("t4_data_bad", 32'(data_bad), 32'd0);

    // en dropped with the buffer full and the stream stalled
    do_reset();
    push(10, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
    check_eq("t5_fill_rd_cnt", 32'(rd_cnt), 32'd2);
    check_eq("t5_fill_valid", 32'(m_valid), 32'd1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    check_eq("t5_stop_rd_cnt", 32'(rd_cnt), 32'd2);
    check_eq("t5_stop_busy", 32'(busy), 32'd1);
    n = 0;
    do begin
      tick(1'b1, 1'b0);
      n++;
    end while (busy && n < 10);
    check_eq("t5_drain_cycles", 32'(n), 32'd4);
    check_eq("t5_rx_cnt", 32'(rx_cnt), 32'd2);
    check_eq("t5_rd_cnt", 32'(rd_cnt), 32'd2);
    check_eq("t5_rule_bad", 32'(rule_bad), 32'd0);
    check_eq("t5_data_bad", 32'(data_bad), 32'd0);

    // Asynchronous reset mid-stream with a full buffer and errors logged
    do_reset();
    base = wr_idx;
    push(FL, 32'hFFFF_FFFF);
    mem[base + 2] = 32'h0;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    check_eq("t6_pre_valid", 32'(m_valid), 32'd1);
    check_eq("t6_pre_err_cnt", 32'(err_cnt), 32'd2);
    #2 tb_rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(m_valid), 32'd0);
    check_eq("t6_rst_data", m_data, 32'h0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("t6_rst_err_flag", 32'(err_flag), 32'd0);
    check_eq("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    do_reset();
    push(4, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    check_eq("t6_restart_rx", 32'(rx_cnt), 32'd4);
    check_eq("t6_restart_data_bad", 32'(data_bad), 32'd0);
    check_eq("t6_restart_err_cnt", 32'(err_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
